// File: rtl/dp_exec_sequencer.sv
// dp_exec_sequencer: five-state controller (IDLE/READ/SHIFT/EXEC/WB) for one data-processing
// command around an external ALU and shifter. Conditional execution is built when DP_COND_EXEC_EN is defined.
module dp_exec_sequencer #(
   parameter int DW  = 32,
   parameter int RAW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [3:0]     cmd_op,
   input  logic [RAW-1:0] cmd_rd,
   input  logic [RAW-1:0] cmd_rn,
   input  logic [RAW-1:0] cmd_rm,
   input  logic [11:0]    cmd_i,
   input  logic [1:0]     cmd_am,
   input  logic           cmd_s,
   input  logic           cmd_wb,
   output logic [RAW-1:0] rf_ra,
   output logic [RAW-1:0] rf_rb,
   input  logic [DW-1:0]  rf_rdata_a,
   input  logic [DW-1:0]  rf_rdata_b,
   output logic           rf_we,
   output logic [RAW-1:0] rf_wa,
   output logic [DW-1:0]  rf_wd,
   output logic [3:0]     alu_op,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic           alu_cin,
   input  logic [DW-1:0]  alu_out,
   input  logic           alu_z,
   input  logic           alu_n,
   input  logic           alu_c,
   input  logic           alu_v,
   output logic [DW-1:0]  sh_rm,
   output logic [11:0]    sh_i,
   output logic [1:0]     sh_am,
   input  logic [DW-1:0]  sh_n,
   output logic           done,
   output logic           res_err,
`ifdef DP_COND_EXEC_EN
   input  logic [3:0]     cmd_cond,
   output logic           res_skip,
`endif
   output logic [3:0]     flags
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_SHIFT, S_EXEC, S_WB} state_t;

   state_t          state_q, state_d;
   logic [3:0]      flags_q, flags_d;
   logic [3:0]      op_q;
   logic [RAW-1:0]  rd_q, rn_q, rm_q;
   logic [11:0]     i_q;
   logic [1:0]      am_q;
   logic            s_q, wb_q, err_q;
   logic [DW-1:0]   opa_q, opb_q, op2_q, res_q;
   logic [3:0]      aflags_q;
   logic            skip;

`ifdef DP_COND_EXEC_EN
   logic skip_q;

   // ARM condition codes over {N,Z,C,V}; 1111 never passes.
   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cc, v;
      {n, z, cc, v} = f;
      case (c)
         4'd0:    cond_pass = z;
         4'd1:    cond_pass = ~z;
         4'd2:    cond_pass = cc;
         4'd3:    cond_pass = ~cc;
         4'd4:    cond_pass = n;
         4'd5:    cond_pass = ~n;
         4'd6:    cond_pass = v;
         4'd7:    cond_pass = ~v;
         4'd8:    cond_pass = cc & ~z;
         4'd9:    cond_pass = ~cc | z;
         4'd10:   cond_pass = (n == v);
         4'd11:   cond_pass = (n != v);
         4'd12:   cond_pass = ~z & (n == v);
         4'd13:   cond_pass = z | (n != v);
         4'd14:   cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   assign skip     = skip_q;
   assign res_skip = (state_q == S_WB) & skip_q;
`else
   assign skip = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      flags_d   = flags_q;
      cmd_ready = 1'b0;
      rf_we     = 1'b0;
      done      = 1'b0;
      res_err   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_d = S_READ;
         end
         S_READ:  state_d = S_SHIFT;
         S_SHIFT: state_d = S_EXEC;
         S_EXEC:  state_d = S_WB;
         S_WB: begin
            state_d = S_IDLE;
            done    = 1'b1;
            res_err = err_q;
            rf_we   = wb_q & ~err_q & ~skip;
            // Logical/transfer ops keep C and V; arithmetic ops take all four.
            if (s_q & ~err_q & ~skip)
               flags_d = (op_q <= 4'd5) ? aflags_q : {aflags_q[3:2], flags_q[1:0]};
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         rd_q     <= '0;
         rn_q     <= '0;
         rm_q     <= '0;
         i_q      <= '0;
         am_q     <= '0;
         s_q      <= 1'b0;
         wb_q     <= 1'b0;
         err_q    <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         op2_q    <= '0;
         res_q    <= '0;
         aflags_q <= '0;
`ifdef DP_COND_EXEC_EN
         skip_q   <= 1'b0;
`endif
      end else begin
         if (state_q == S_IDLE && cmd_valid) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            rn_q  <= cmd_rn;
            rm_q  <= cmd_rm;
            i_q   <= cmd_i;
            am_q  <= cmd_am;
            s_q   <= cmd_s;
            wb_q  <= cmd_wb;
            err_q <= (cmd_op > 4'd12);
`ifdef DP_COND_EXEC_EN
            skip_q <= ~cond_pass(cmd_cond, flags_q);
`endif
         end
         if (state_q == S_READ) begin
            opa_q <= rf_rdata_a;
            opb_q <= rf_rdata_b;
         end
         if (state_q == S_SHIFT) op2_q <= sh_n;
         if (state_q == S_EXEC) begin
            res_q    <= alu_out;
            aflags_q <= {alu_n, alu_z, alu_c, alu_v};
         end
      end
   end

   // Datapath drives come straight from captured registers, so they hold between uses.
   assign rf_ra   = rn_q;
   assign rf_rb   = rm_q;
   assign rf_wa   = rd_q;
   assign rf_wd   = res_q;
   assign sh_rm   = opb_q;
   assign sh_i    = i_q;
   assign sh_am   = am_q;
   assign alu_op  = op_q;
   assign alu_a   = opa_q;
   assign alu_b   = op2_q;
   assign alu_cin = flags_q[1];
   assign flags   = flags_q;

endmodule

// File: tb/tb_dp_exec_sequencer.sv
// Bench for dp_exec_sequencer: behavioural register file, ALU and shifter around the DUT,
// directed steps followed by randomized commands checked against a command-level model.
module tb_dp_exec_sequencer;
   localparam int DW  = 32;
   localparam int RAW = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic [3:0]     cmd_op = '0;
   logic [RAW-1:0] cmd_rd = '0, cmd_rn = '0, cmd_rm = '0;
   logic [11:0]    cmd_i = '0;
   logic [1:0]     cmd_am = '0;
   logic           cmd_s = 1'b0, cmd_wb = 1'b0;
   logic [RAW-1:0] rf_ra, rf_rb, rf_wa;
   logic [DW-1:0]  rf_rdata_a, rf_rdata_b, rf_wd;
   logic           rf_we;
   logic [3:0]     alu_op;
   logic [DW-1:0]  alu_a, alu_b, alu_out;
   logic           alu_cin, alu_z, alu_n, alu_c, alu_v;
   logic [DW-1:0]  sh_rm, sh_n;
   logic [11:0]    sh_i;
   logic [1:0]     sh_am;
   logic           done, res_err;
   logic [3:0]     flags;

   int checks = 0;
   int failures = 0;

   logic [31:0] rf  [16];
   logic [31:0] mrf [16];
   logic [3:0]  mflags = 4'b0000;
   logic        tb_wr = 1'b0;
   logic [3:0]  tb_wa = '0;
   logic [31:0] tb_wd = '0;

   always #5 clk = ~clk;

   dp_exec_sequencer #(.DW(DW), .RAW(RAW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
      .cmd_i(cmd_i), .cmd_am(cmd_am), .cmd_s(cmd_s), .cmd_wb(cmd_wb),
      .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
      .sh_rm(sh_rm), .sh_i(sh_i), .sh_am(sh_am), .sh_n(sh_n),
      .done(done), .res_err(res_err), .flags(flags)
   );

   // Shifter: 00 imm8, 01 Rm, 10 Rm LSL i[11:7], 11 Rm shifted by type i[6:5] amount i[11:7].
   function automatic logic [31:0] sh_f(input logic [31:0] rm, input logic [11:0] i, input logic [1:0] am);
      int amt;
      amt = int'(i[11:7]);
      case (am)
         2'b00: sh_f = {24'd0, i[7:0]};
         2'b01: sh_f = rm;
         2'b10: sh_f = rm << amt;
         default: case (i[6:5])
            2'b00:   sh_f = rm << amt;
            2'b01:   sh_f = rm >> amt;
            2'b10:   sh_f = $unsigned($signed(rm) >>> amt);
            default: sh_f = (amt == 0) ? rm : ((rm >> amt) | (rm << (32 - amt)));
         endcase
      endcase
   endfunction

   // ALU returns {N,Z,C,V,result}. Logical ops report C=~cin, V=1 so a wrong flag merge shows.
   function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic cin);
      logic [32:0] t;
      logic [31:0] r;
      logic c, v;
      t = '0; r = '0; c = ~cin; v = 1'b1;
      case (op)
         4'd0: t = {1'b0, a} + {1'b0, b};
         4'd1: t = {1'b0, a} + {1'b0, b} + {32'd0, cin};
         4'd2: t = {1'b0, a} - {1'b0, b};
         4'd3: t = {1'b0, a} - {1'b0, b} - {32'd0, cin};
         4'd4: t = {1'b0, b} - {1'b0, a};
         4'd5: t = {1'b0, b} - {1'b0, a} - {32'd0, cin};
         4'd6: r = a & b;
         4'd7: r = a | b;
         4'd8: r = a ^ b;
         4'd9: r = a & ~b;
         4'd10: r = b;
         4'd11: r = ~b;
         4'd12: r = a & b;
         default: r = '0;
      endcase
      if (op <= 4'd5) begin
         r = t[31:0];
         c = t[32];
         if (op <= 4'd1) v = (a[31] == b[31]) && (r[31] != a[31]);
         else if (op <= 4'd3) v = (a[31] != b[31]) && (r[31] != a[31]);
         else v = (a[31] != b[31]) && (r[31] != b[31]);
      end
      alu_f = {r[31], (r == 32'd0), c, v, r};
   endfunction

   logic [35:0] alu_res;
   assign alu_res    = alu_f(alu_op, alu_a, alu_b, alu_cin);
   assign {alu_n, alu_z, alu_c, alu_v, alu_out} = alu_res;
   assign sh_n       = sh_f(sh_rm, sh_i, sh_am);
   assign rf_rdata_a = rf[rf_ra];
   assign rf_rdata_b = rf[rf_rb];

   always @(posedge clk) begin
      if (tb_wr) rf[tb_wa] <= tb_wd;
      else if (rf_we) rf[rf_wa] <= rf_wd;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_reg(input logic [3:0] a, input logic [31:0] d);
      tb_wa = a; tb_wd = d; tb_wr = 1'b1;
      mrf[a] = d;
      @(posedge clk); #1;
      tb_wr = 1'b0;
   endtask

   // One command, from accept to the first idle cycle after retirement.
   task automatic run_cmd(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rn,
                          input logic [3:0] rm, input logic [11:0] i, input logic [1:0] am,
                          input logic s, input logic wb);
      logic [35:0] r;
      logic        e_err, e_we;
      int          n;
      e_err = (op > 4'd12);
      e_we  = wb & ~e_err;
      r     = alu_f(op, mrf[rn], sh_f(mrf[rm], i, am), mflags[1]);
      n = 0;
      while (cmd_ready !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
      check("ready_before_accept", 64'(cmd_ready), 64'(1'b1));
      cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
      cmd_i = i; cmd_am = am; cmd_s = s; cmd_wb = wb; cmd_valid = 1'b1;
      @(posedge clk); #1;
      // Garbage on the command bus while busy must be ignored.
      cmd_op = 4'($urandom); cmd_rd = 4'($urandom); cmd_rn = 4'($urandom); cmd_rm = 4'($urandom);
      cmd_i = 12'($urandom); cmd_am = 2'($urandom); cmd_s = 1'($urandom); cmd_wb = 1'($urandom);
      check("busy_not_ready", 64'(cmd_ready), 64'(1'b0));
      @(posedge clk); #1;
      check("done_early_shift", 64'(done), 64'(1'b0));
      @(posedge clk); #1;
      check("done_early_exec", 64'(done | rf_we), 64'(1'b0));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("done_wb", 64'(done), 64'(1'b1));
      check("res_err", 64'(res_err), 64'(e_err));
      check("rf_we", 64'(rf_we), 64'(e_we));
      if (e_we) begin
         check("rf_wa", 64'(rf_wa), 64'(rd));
         check("rf_wd", 64'(rf_wd), 64'(r[31:0]));
      end
      if (s && !e_err) mflags = (op <= 4'd5) ? r[35:32] : {r[35:34], mflags[1:0]};
      if (e_we) mrf[rd] = r[31:0];
      @(posedge clk); #1;
      check("done_after", 64'(done | rf_we), 64'(1'b0));
      check("ready_after", 64'(cmd_ready), 64'(1'b1));
      check("flags", 64'(flags), 64'(mflags));
      check("rf_content", 64'(rf[rd]), 64'(mrf[rd]));
   endtask

   initial begin
      #1;
      for (int k = 0; k < 16; k++) set_reg(4'(k), 32'd0);
      // Reset state, then a quiet idle period.
      check("rst_ready", 64'(cmd_ready), 64'(1'b1));
      check("rst_flags", 64'(flags), 64'(4'b0000));
      check("rst_we_done", 64'({rf_we, done, res_err}), 64'(3'b000));
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("idle_quiet", 64'({cmd_ready, flags, rf_we, done}), 64'(7'b1_0000_00));
      end

      set_reg(4'd0, 32'd5); set_reg(4'd1, 32'd7);
      run_cmd(4'd0, 4'd2, 4'd0, 4'd1, 12'd0, 2'b01, 1'b0, 1'b1);
      check("add_rd", 64'(rf[2]), 64'(32'd12));
      check("add_flags", 64'(flags), 64'(4'b0000));

      set_reg(4'd0, 32'd3); set_reg(4'd1, 32'd3);
      run_cmd(4'd2, 4'd2, 4'd0, 4'd1, 12'd0, 2'b01, 1'b1, 1'b1);
      check("sub_flags", 64'(flags), 64'(4'b0100));
      set_reg(4'd0, 32'h8000_0000); set_reg(4'd1, 32'hFFFF_FFFF);
      run_cmd(4'd6, 4'd2, 4'd0, 4'd1, 12'd0, 2'b01, 1'b1, 1'b1);
      check("and_rd", 64'(rf[2]), 64'(32'h8000_0000));
      check("and_flags", 64'(flags), 64'(4'b1000));

      set_reg(4'd0, 32'hFFFF_FFFF); set_reg(4'd1, 32'd1);
      run_cmd(4'd0, 4'd2, 4'd0, 4'd1, 12'd0, 2'b01, 1'b1, 1'b1);
      check("carry_flags", 64'(flags), 64'(4'b0110));
      set_reg(4'd0, 32'd1);
      run_cmd(4'd1, 4'd2, 4'd0, 4'd1, 12'd0, 2'b01, 1'b1, 1'b1);
      check("adc_rd", 64'(rf[2]), 64'(32'd3));

      set_reg(4'd1, 32'h8000_0000);
      run_cmd(4'd10, 4'd3, 4'd0, 4'd1, 12'h240, 2'b11, 1'b1, 1'b1);
      check("asr_rd", 64'(rf[3]), 64'(32'hF800_0000));
      check("asr_n", 64'(flags[3]), 64'(1'b1));
      run_cmd(4'd13, 4'd3, 4'd0, 4'd1, 12'd0, 2'b01, 1'b1, 1'b1);
      check("illegal_flags", 64'(flags), 64'(4'b1000));

      // Reset while the command is in EXEC.
      set_reg(4'd4, 32'h1234_5678);
      cmd_op = 4'd0; cmd_rd = 4'd4; cmd_rn = 4'd0; cmd_rm = 4'd1; cmd_i = '0;
      cmd_am = 2'b01; cmd_s = 1'b1; cmd_wb = 1'b1; cmd_valid = 1'b1;
      @(posedge clk); #1; cmd_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0; #1;
      mflags = 4'b0000;
      check("midrst_quiet", 64'({rf_we, done}), 64'(2'b00));
      check("midrst_ready", 64'(cmd_ready), 64'(1'b1));
      check("midrst_flags", 64'(flags), 64'(4'b0000));
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("midrst_no_pulse", 64'({rf_we, done, cmd_ready}), 64'(3'b001));
      end
      check("midrst_no_write", 64'(rf[4]), 64'(32'h1234_5678));

      // Randomized commands, including illegal opcodes and compare-style ops.
      for (int k = 0; k < 40; k++) begin
         set_reg(4'($urandom), $urandom);
         set_reg(4'($urandom), (k % 4 == 0) ? 32'h8000_0000 : $urandom);
         run_cmd(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                 12'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(3, 0) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
